// File: rtl/div_seq_pkg.sv
// Shared defines for the sequential divider: state encodings, iteration
// count and the E-stage opcodes used by the hazard and ALU logic.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER   = DIV_DATA_W;

  typedef logic [1:0] div_state_t;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_DIVZERO = 2'b01;
  localparam logic [1:0] S_ON      = 2'b10;
  localparam logic [1:0] S_END     = 2'b11;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq_if.sv
// Pipeline <-> divider handshake: request/operands in, {HI, LO} result out.
interface div_seq_if import div_seq_pkg::*; #(parameter int DATA_W = DIV_DATA_W);

  logic                  start;
  logic                  signed_div;
  logic                  annul;
  logic [DATA_W-1:0]     opdata_a;
  logic [DATA_W-1:0]     opdata_b;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  busy;

  modport master (
    output start, signed_div, annul, opdata_a, opdata_b,
    input  result, ready, busy
  );

  modport slave (
    input  start, signed_div, annul, opdata_a, opdata_b,
    output result, ready, busy
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: work = {spare, remainder, dividend/quotient}.
module div_step import div_seq_pkg::*; #(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [2*DATA_W:0]  work,
  input  logic [DATA_W-1:0]  divisor,
  output logic [2*DATA_W:0]  work_next
);

  logic [DATA_W:0] trial;
  logic            unused_msb;

  // The spare top bit only exists to hold the shifted-out restore value.
  assign unused_msb = work[2*DATA_W];

  assign trial = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]} - {1'b0, divisor};

  always_comb begin
    if (!trial[DATA_W]) begin
      work_next = {trial, work[DATA_W-2:0], 1'b1};
    end else begin
      work_next = {work[2*DATA_W-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per cycle, sign fix-up on the
// last step, result held in END until the pipeline drops start.
//
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_DIVZERO | divisor was zero, result forced to zero
//   S_ON      | iterating, one shift-subtract per cycle
//   S_END     | result presented, ready from the second END cycle
module div_seq import div_seq_pkg::*; #(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic      clk,
  input  logic      resetn,
  div_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W:0]     work;
  logic [2*DATA_W:0]     work_step;
  logic [DATA_W-1:0]     divisor;
  logic                  quo_neg;
  logic                  rem_neg;
  logic                  ready_q;
  logic [2*DATA_W-1:0]   result_q;

  logic [DATA_W-1:0]     a_mag;
  logic [DATA_W-1:0]     b_mag;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;
  logic                  a_neg;
  logic                  b_neg;

  assign a_neg = bus.signed_div & bus.opdata_a[DATA_W-1];
  assign b_neg = bus.signed_div & bus.opdata_b[DATA_W-1];
  assign a_mag = a_neg ? -bus.opdata_a : bus.opdata_a;
  assign b_mag = b_neg ? -bus.opdata_b : bus.opdata_b;

  div_step #(.DATA_W(DATA_W)) u_step (
    .work      (work),
    .divisor   (divisor),
    .work_next (work_step)
  );

  // Fix-up is applied to the last step's output so END only has to copy.
  assign quo_fix = quo_neg ? -work_step[DATA_W-1:0] : work_step[DATA_W-1:0];
  assign rem_fix = rem_neg ? -work_step[2*DATA_W-1:DATA_W] : work_step[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else if (bus.annul) begin
      state    <= S_IDLE;
      cnt      <= '0;
      work     <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.opdata_b == '0) begin
              state <= S_DIVZERO;
            end else begin
              state   <= S_ON;
              cnt     <= '0;
              work    <= {{(DATA_W+1){1'b0}}, a_mag};
              divisor <= b_mag;
              quo_neg <= a_neg ^ b_neg;
              rem_neg <= a_neg;
            end
          end
        end
        S_DIVZERO: begin
          work  <= '0;
          state <= S_END;
        end
        S_ON: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            work  <= {1'b0, rem_fix, quo_fix};
            state <= S_END;
          end else begin
            work <= work_step;
          end
        end
        S_END: begin
          if (!bus.start) begin
            state    <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end else begin
            ready_q  <= 1'b1;
            result_q <= work[2*DATA_W-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = (state != S_IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divides push expected {HI, LO} and
// latency; a negedge monitor pops and checks on each rising ready.
module tb_div_seq;

  typedef struct {
    logic [63:0] res;
    int          e0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   edge_cnt = 0;
  int   total = 0;
  int   passed = 0;
  bit   ready_prev = 1'b0;
  exp_t exp_q[$];

  div_seq_if #(.DATA_W(32)) bus ();

  div_seq #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: actual %h required %h", name, act, want);
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (bus.ready) check("ready_only_when_busy", 64'(bus.busy), 64'd1);
      if (bus.ready && !ready_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_ready: actual result %h required no ready", bus.result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", bus.result, e.res);
          check("latency", 64'(edge_cnt - e.e0), 64'(e.lat));
        end
      end
    end
    ready_prev = bus.ready;
  end

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] want, input int lat,
                         input bit mutate, input bit align);
    int  busy_cyc;
    bit  got;
    exp_t e;
    if (align) begin
      @(posedge clk);
      #1;
    end
    bus.opdata_a   = a;
    bus.opdata_b   = b;
    bus.signed_div = sgn;
    bus.start      = 1'b1;
    e.res = want;
    e.e0  = edge_cnt + 1;
    e.lat = lat;
    exp_q.push_back(e);
    busy_cyc = 0;
    got = 1'b0;
    for (int w = 0; w < 100 && !got; w++) begin
      @(posedge clk);
      #1;
      if (mutate && w == 5) begin
        bus.opdata_a   = ~a;
        bus.opdata_b   = 32'h3;
        bus.signed_div = ~sgn;
      end
      if (bus.ready) got = 1'b1;
      else if (bus.busy) busy_cyc++;
    end
    bus.start = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL %s timeout: actual no ready required ready within 100 cycles", tag);
    end else begin
      check({tag, " busy_cycles"}, 64'(busy_cyc), 64'(lat));
      @(posedge clk);
      #1;
      check({tag, " ready_after_drop"}, 64'(bus.ready), 64'd0);
      check({tag, " busy_after_drop"}, 64'(bus.busy), 64'd0);
      check({tag, " result_after_drop"}, bus.result, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata_a   = '0;
    bus.opdata_b   = '0;
    #1;
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_result", bus.result, 64'd0);
    #11 resetn = 1'b1;

    run_div("divu_100_7",    32'd100,       32'd7,          1'b0, {32'h2, 32'hE},          33, 1'b0, 1'b1);
    run_div("div_m100_7",    32'hFFFFFF9C,  32'd7,          1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b0, 1'b1);
    run_div("div_100_m7",    32'd100,       32'hFFFFFFF9,   1'b1, {32'h2, 32'hFFFFFFF2},   33, 1'b0, 1'b1);
    run_div("div_min_m1",    32'h80000000,  32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000},   33, 1'b0, 1'b1);
    run_div("divu_min_max",  32'h80000000,  32'hFFFFFFFF,   1'b0, {32'h80000000, 32'h0},   33, 1'b0, 1'b1);
    run_div("divu_max_1",    32'hFFFFFFFF,  32'd1,          1'b0, {32'h0, 32'hFFFFFFFF},   33, 1'b0, 1'b1);
    run_div("divu_7_100",    32'd7,         32'd100,        1'b0, {32'h7, 32'h0},          33, 1'b0, 1'b1);
    run_div("div_zero",      32'd5,         32'd0,          1'b1, 64'h0,                   2,  1'b0, 1'b1);
    run_div("div_mutate",    32'hFFFFFF9C,  32'd7,          1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b1, 1'b1);

    // start with annul in IDLE must not leave IDLE
    @(posedge clk);
    #1;
    bus.opdata_a = 32'd9;
    bus.opdata_b = 32'd3;
    bus.start    = 1'b1;
    bus.annul    = 1'b1;
    @(posedge clk);
    #1;
    check("start_annul_idle_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;

    // annul at iteration 10, then an immediate new request
    @(posedge clk);
    #1;
    bus.opdata_a   = 32'd100;
    bus.opdata_b   = 32'd7;
    bus.signed_div = 1'b0;
    bus.start      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_busy", 64'(bus.busy), 64'd0);
    check("annul_ready", 64'(bus.ready), 64'd0);
    bus.annul = 1'b0;
    run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, 1'b0, 1'b0);

    // asynchronous reset at iteration 20, then start right at release
    @(posedge clk);
    #1;
    bus.opdata_a   = 32'd100;
    bus.opdata_b   = 32'd7;
    bus.signed_div = 1'b0;
    bus.start      = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    resetn    = 1'b0;
    bus.start = 1'b0;
    #1;
    check("async_reset_ready", 64'(bus.ready), 64'd0);
    check("async_reset_busy", 64'(bus.busy), 64'd0);
    check("async_reset_result", bus.result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_div("after_reset", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
